// File: rtl/param_updown_counter_if.sv
// Control and status bundle for one param_updown_counter stage.
// No handshake: controls are sampled on every rising clk edge; count/wrap/ovf are registered, tc is combinational.
interface param_updown_counter_if #(
    parameter int WIDTH = 4
);
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             up;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;
    logic             ovf;

    modport master (
        output clr, load, load_val, en, up,
        input  count, tc, wrap, ovf
    );

    modport slave (
        input  clr, load, load_val, en, up,
        output count, tc, wrap, ovf
    );
endinterface

// File: rtl/param_updown_counter.sv
// Modulo-N up/down counter with clear, clamped load, wrap/saturate modes,
// cascade terminal count, one-cycle wrap pulse and sticky overflow.
module param_updown_counter #(
    parameter int      WIDTH    = 4,
    parameter longint  MODULUS  = 16,
    parameter bit      SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    param_updown_counter_if.slave bus
);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("param_updown_counter: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("param_updown_counter: MODULUS must be 2..2**WIDTH");
    end

    // Held in WIDTH+1 bits so MODULUS = 2**WIDTH does not overflow.
    localparam logic [WIDTH:0] TERM = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             at_top;
    logic             at_zero;

    assign at_top  = ({1'b0, count_q} == TERM);
    assign at_zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (bus.clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (bus.load) begin
            if ({1'b0, bus.load_val} > TERM) count_d = TERM[WIDTH-1:0];
            else                             count_d = bus.load_val;
        end else if (bus.en) begin
            if (bus.up) begin
                if (at_top) begin
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                    if (!SATURATE) count_d = '0;
                end else begin
                    // Guarded by at_top, so this never exceeds the modulus.
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    wrap_d = 1'b1;
                    ovf_d  = 1'b1;
                    if (!SATURATE) count_d = TERM[WIDTH-1:0];
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.ovf   = ovf_q;
    assign bus.tc    = bus.en & (bus.up ? at_top : at_zero);

endmodule
